// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : Row-scans a 4x4 matrix keypad, picks the first pressed key of
//            each scan frame, debounces it over DEBOUNCE_FRAMES identical
//            frames and presents the committed code as kb_idx = {valid, idx}.
//            Key index: 0-9 -> 0x0-0x9, A-D -> 0xA-0xD, '*' -> 0xE, '#' -> 0xF.
// Ports    : clk     in   1   system clock
//            rst     in   1   synchronous active-high reset
//            col_n   in   4   keypad columns, active-low, asynchronous
//            row_n   out  4   keypad row drive, active-low, one-hot-zero
//            kb_idx  out  5   {valid, idx[3:0]}
// Config   : KB_STICKY_EN - when defined, a release keeps the last index in
//            kb_idx[3:0] with valid cleared; otherwise a release gives 5'b0.
// Revision : 1.0  initial release
// ============================================================================

`ifndef KBCODE_WID
`define KBCODE_WID 5
`endif

module keypad_scanner #(
    parameter logic [15:0] SCAN_DIV        = 16'd50000,
    parameter logic [7:0]  DEBOUNCE_FRAMES = 8'd4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             col_n,
    output logic [3:0]             row_n,
    output logic [`KBCODE_WID-1:0] kb_idx
);

    typedef enum logic [0:0] {
        ST_SCAN = 1'b0,
        ST_EVAL = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_row;
    logic [15:0] r_slot;
    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [15:0] r_frame;     // bit r*4+c set when key (r,c) was seen pressed
    logic [3:0]  r_row_n;
    logic [4:0]  r_prev;
    logic [7:0]  r_cnt;
    logic [4:0]  r_kb;

    logic        w_slot_last;
    logic [4:0]  w_cand;
    logic [7:0]  w_cnt_nxt;
    logic        w_commit;
    logic [4:0]  w_rel_code;
    logic [4:0]  w_kb_nxt;

    // Physical position (row*4 + col) to key index.
    function automatic logic [3:0] key_code(input logic [3:0] pos);
        logic [3:0] code;
        case (pos)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign w_slot_last = (r_slot == SCAN_DIV - 16'd1);

    // ------------------------------------------------------------------
    // FSM: state register and next-state decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_SCAN) begin
            if (w_slot_last && (r_row == 2'd3)) begin
                w_state_nxt = ST_EVAL;
            end
        end else begin
            w_state_nxt = ST_SCAN;
        end
    end

    // ------------------------------------------------------------------
    // Frame candidate and debounce decision
    // ------------------------------------------------------------------
    // Walk from the last scan position down so the earliest pressed key in
    // scan order is the one left standing.
    always_comb begin
        w_cand = 5'b0_0000;
        for (int i = 15; i >= 0; i--) begin
            if (r_frame[i]) begin
                w_cand = {1'b1, key_code(4'(i))};
            end
        end
    end

    always_comb begin
        w_cnt_nxt = 8'd1;
        if (w_cand == r_prev) begin
            w_cnt_nxt = (r_cnt >= DEBOUNCE_FRAMES) ? DEBOUNCE_FRAMES
                                                   : r_cnt + 8'd1;
        end
    end

    assign w_commit = (w_cnt_nxt == DEBOUNCE_FRAMES);

`ifdef KB_STICKY_EN
    assign w_rel_code = {1'b0, r_kb[3:0]};
`else
    assign w_rel_code = 5'b0_0000;
`endif

    assign w_kb_nxt = w_cand[4] ? w_cand : w_rel_code;

    // ------------------------------------------------------------------
    // Datapath: synchronizer, scan counters, row drive, debounce state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
            r_row   <= 2'd0;
            r_slot  <= 16'd0;
            r_frame <= 16'd0;
            r_row_n <= 4'b1110;
            r_prev  <= 5'b0_0000;
            r_cnt   <= 8'd0;
            r_kb    <= 5'b0_0000;
        end else begin
            r_sync1 <= col_n;
            r_sync2 <= r_sync1;
            if (r_state == ST_SCAN) begin
                if (w_slot_last) begin
                    r_slot <= 16'd0;
                    // Last cycle of the slot: columns have settled through
                    // the synchronizer for this row.
                    r_frame[{r_row, 2'b00} +: 4] <= ~r_sync2;
                    if (r_row == 2'd3) begin
                        r_row_n <= 4'b1111;
                    end else begin
                        r_row   <= r_row + 2'd1;
                        r_row_n <= ~(4'b0001 << (r_row + 2'd1));
                    end
                end else begin
                    r_slot <= r_slot + 16'd1;
                end
            end else begin
                r_row   <= 2'd0;
                r_row_n <= 4'b1110;
                r_prev  <= w_cand;
                r_cnt   <= w_cnt_nxt;
                if (w_commit) begin
                    r_kb <= w_kb_nxt;
                end
            end
        end
    end

    assign row_n  = r_row_n;
    assign kb_idx = r_kb;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Self-checking bench for keypad_scanner (SCAN_DIV=4,
//            DEBOUNCE_FRAMES=3). A keypad model turns a pressed-key mask into
//            col_n; a frame-level reference model predicts row_n and kb_idx
//            every cycle, alongside directed vectors and corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SD    = 4;
    localparam int DF    = 3;
    localparam int FRAME = 4 * SD + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [4:0]  kb_idx;
    logic [15:0] keys = 16'h0000;   // bit r*4+c = key at row r, column c held

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV        (16'd4),
        .DEBOUNCE_FRAMES (8'd3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .col_n  (col_n),
        .row_n  (row_n),
        .kb_idx (kb_idx)
    );

    // Passive matrix: a held key pulls its column low when its row is driven.
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && (row_n[r] == 1'b0)) begin
                    col_n[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] rel(input logic [3:0] idx);
`ifdef KB_STICKY_EN
        return {1'b0, idx};
`else
        return 5'b0_0000 & {1'b0, idx} & 5'b0;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Reference model: one frame = 17 cycles counted from reset release.
    // Row r is low in phases 4r..4r+3; the sample taken at the end of the
    // slot sees the keys as they were two cycles earlier (phase 4r+1).
    // Phase 16 evaluates; the result is visible from the next cycle.
    // ------------------------------------------------------------------
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    logic [3:0] snap [4];
    int         m_ph   = 0;
    int         m_last = -1;
    int         m_cnt  = 0;
    logic [4:0] m_prev = 5'b0;
    logic [4:0] m_kb   = 5'b0;
    logic       rst_d  = 1'b0;
    logic       m_on   = 1'b0;

    function automatic logic [3:0] exp_row(input int ph);
        return (ph < 4 * SD) ? ~(4'b0001 << (ph / SD)) : 4'b1111;
    endfunction

    task automatic model_eval();
        logic [15:0] fr;
        logic [4:0]  cand;
        fr   = {snap[3], snap[2], snap[1], snap[0]};
        cand = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (fr[i] && !cand[4]) cand = {1'b1, keymap[i]};
        end
        if (cand == m_prev) begin
            m_cnt = (m_cnt + 1 > DF) ? DF : m_cnt + 1;
        end else begin
            m_cnt  = 1;
            m_prev = cand;
        end
        if (m_cnt == DF) begin
            m_kb = cand[4] ? cand : rel(m_kb[3:0]);
        end
    endtask

    always @(negedge clk) begin
        if (rst_d) begin
            m_ph   = 0;
            m_cnt  = 0;
            m_prev = 5'b0;
            m_kb   = 5'b0;
            m_on   = 1'b1;
        end
        if (m_on) begin
            check("model_row_n", {1'b0, row_n}, {1'b0, exp_row(m_ph)});
            check("model_kb_idx", kb_idx, m_kb);
            if ((m_ph < 4 * SD) && (m_ph % SD == 1)) begin
                snap[m_ph / SD] = keys[(m_ph / SD) * 4 +: 4];
            end
            if (m_ph == 4 * SD) model_eval();
            m_last = m_ph;
            m_ph   = (m_ph + 1) % FRAME;
        end
        rst_d = rst;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [15:0] keys;
        int          hold;
        logic [4:0]  exp;
    } vec_t;

    vec_t       tv [12];
    logic [3:0] walk [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111};

    initial begin
        tv[0]  = '{16'h0000, 75, rel(4'h0)};     // idle after reset
        tv[1]  = '{16'h0020, 75, 5'b1_0101};     // '5'
        tv[2]  = '{16'h0020, 40, 5'b1_0101};     // '5' still held
        tv[3]  = '{16'h0000, 75, rel(4'h5)};     // release
        tv[4]  = '{16'h1000, 75, 5'b1_1110};     // '*'
        tv[5]  = '{16'h2000, 75, 5'b1_0000};     // '0' without release
        tv[6]  = '{16'h0008, 75, 5'b1_1010};     // 'A'
        tv[7]  = '{16'h0500, 75, 5'b1_0111};     // '7' and '9': '7' first
        tv[8]  = '{16'h0000, 75, rel(4'h7)};
        tv[9]  = '{16'h8000, 75, 5'b1_1101};     // 'D'
        tv[10] = '{16'h0100, 75, 5'b1_0111};     // '7'
        tv[11] = '{16'h0000, 75, rel(4'h7)};

        // Reset held 3 cycles
        rst  = 1'b1;
        keys = 16'h0000;
        tick(3);
        check("reset_kb_idx", kb_idx, 5'b0_0000);
        check("reset_row_n", {1'b0, row_n}, 5'b0_1110);
        rst = 1'b0;

        // Row walk over the first frame
        for (int i = 0; i < FRAME; i++) begin
            check($sformatf("row_walk%0d", i), {1'b0, row_n}, {1'b0, walk[(i < 4 * SD) ? i / SD : 4]});
            tick(1);
        end

        // Directed vectors
        for (int v = 0; v < 12; v++) begin
            keys = tv[v].keys;
            tick(tv[v].hold);
            check($sformatf("vec%0d", v), kb_idx, tv[v].exp);
        end

        // '#' chattering faster than the debounce window never commits
        for (int i = 0; i < 60; i++) begin
            keys = (i % 2 == 0) ? 16'h4000 : 16'h0000;
            tick(2);
        end
        keys = 16'h0000;
        tick(1);
        check("bounce_no_commit", kb_idx, rel(4'h7));

        // '#' chattering every 10 cycles, then held
        for (int i = 0; i < 12; i++) begin
            keys = (i % 2 == 0) ? 16'h4000 : 16'h0000;
            tick(10);
        end
        keys = 16'h4000;
        tick(72);
        check("hash_held", kb_idx, 5'b1_1111);
        keys = 16'h0000;
        tick(72);
        check("hash_release", kb_idx, rel(4'hF));

        // '1'+'D' together, then release '1' only: no invalid cycle between
        keys = 16'h8001;
        tick(75);
        check("one_and_d", kb_idx, 5'b1_0001);
        keys = 16'h8000;
        for (int i = 0; i < 75; i++) begin
            tick(1);
            check("no_gap_valid", {4'b0, kb_idx[4]}, 5'b0_0001);
        end
        check("d_after_one", kb_idx, 5'b1_1101);

        // '8' held, reset pulsed in the middle of row 2's slot
        keys = 16'h0200;
        tick(75);
        check("eight_held", kb_idx, 5'b1_1000);
        for (int n = 0; n < 40 && m_last != 8; n++) tick(1);
        check("align_row2", 5'(m_last), 5'd8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midreset_kb_idx", kb_idx, 5'b0_0000);
        check("midreset_row_n", {1'b0, row_n}, 5'b0_1110);
        tick(40);
        check("requalify_pending", kb_idx, 5'b0_0000);
        tick(32);
        check("requalify_done", kb_idx, 5'b1_1000);

        // Random key activity, checked cycle by cycle against the model
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 3))
                0:       keys = 16'h0000;
                1, 2:    keys = 16'h0001 << $urandom_range(0, 15);
                default: keys = (16'h0001 << $urandom_range(0, 15)) |
                                (16'h0001 << $urandom_range(0, 15));
            endcase
            tick($urandom_range(3, 60));
        end
        keys = 16'h0000;
        tick(80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
